// File: rtl/apb_i2c_seq_pkg.sv
// Shared types and defaults for the two-requester APB front-end to the i2c controller.
package apb_i2c_seq_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/apb_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not win last time wins.
module apb_rr_pick2
  import apb_i2c_seq_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   last_grant_i,
  output logic       valid_o,
  output req_idx_t   grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/apb_i2c_seq_arb.sv
// Shares one APB slave port between two requesters with round-robin arbitration.
// Optional ACCESS timeout enabled by defining APB_I2C_SEQ_ARB_TIMEOUT_EN.
module apb_i2c_seq_arb
  import apb_i2c_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  input  logic              WRITE0,
  input  logic              WRITE1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSELx,
  output logic              PENABLE,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  state_e            state_q;
  req_idx_t          last_grant_q;
  req_idx_t          grant_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [1:0] req_elig;
  logic       pick_valid;
  req_idx_t   pick_grant;
  logic       timed_out;

  // A requester whose DONE is high this cycle is still holding REQ from the finished transfer.
  assign req_elig = {REQ1 & ~done1_q, REQ0 & ~done0_q};

  apb_rr_pick2 u_pick (
    .req_i        (req_elig),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

`ifdef APB_I2C_SEQ_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timed_out = ~PREADY & (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q      <= pick_grant;
            last_grant_q <= pick_grant;
            paddr_q      <= pick_grant ? ADDR1  : ADDR0;
            pwdata_q     <= pick_grant ? WDATA1 : WDATA0;
            pwrite_q     <= pick_grant ? WRITE1 : WRITE0;
            psel_q       <= 1'b1;
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timed_out) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
            done0_q   <= ~grant_q;
            done1_q   <= grant_q;
            rdata_q   <= (PREADY && !pwrite_q) ? PRDATA : '0;
            err_q     <= PREADY ? PSLVERR : 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSELx   = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign DONE0   = done0_q;
  assign DONE1   = done1_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_apb_i2c_seq_arb.sv
// Self-checking bench for apb_i2c_seq_arb: transaction-level model compared every cycle plus directed literal checks.
module tb_apb_i2c_seq_arb;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_I2C_SEQ_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic          PCLK, PRESETn;
  logic          REQ0, REQ1, WRITE0, WRITE1;
  logic [AW-1:0] ADDR0, ADDR1, PADDR;
  logic [DW-1:0] WDATA0, WDATA1, RDATA, PWDATA, PRDATA;
  logic          DONE0, DONE1, ERR, PWRITE, PSELx, PENABLE, PREADY, PSLVERR;

  apb_i2c_seq_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .WRITE0(WRITE0), .WRITE1(WRITE1),
    .DONE0(DONE0), .DONE1(DONE1), .RDATA(RDATA), .ERR(ERR),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: a transfer is either absent or N cycles old since grant.
  bit          m_busy = 0, m_owner = 0, m_last = 1, m_write = 0;
  int          m_age = 0, m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, e_rdata = '0;
  bit          e_done0 = 0, e_done1 = 0, e_err = 0;
  bit          nd0, nd1, el0, el1;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_write = 0; m_age = 0; m_wait = 0;
      m_addr = '0; m_wdata = '0; e_rdata = '0; e_done0 = 0; e_done1 = 0; e_err = 0;
    end else begin
      nd0 = 0; nd1 = 0;
      if (!m_busy) begin
        el0 = REQ0 && !e_done0;
        el1 = REQ1 && !e_done1;
        if (el0 || el1) begin
          m_owner = (el0 && el1) ? !m_last : el1;
          m_last  = m_owner;
          m_addr  = m_owner ? ADDR1 : ADDR0;
          m_wdata = m_owner ? WDATA1 : WDATA0;
          m_write = m_owner ? WRITE1 : WRITE0;
          m_busy  = 1; m_age = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2; m_wait = 0;
      end else if (PREADY) begin
        m_busy = 0;
        if (m_owner) nd1 = 1; else nd0 = 1;
        e_err   = PSLVERR;
        e_rdata = m_write ? '0 : PRDATA;
      end else begin
`ifdef APB_I2C_SEQ_ARB_TIMEOUT_EN
        if (m_wait == TO - 1) begin
          m_busy = 0;
          if (m_owner) nd1 = 1; else nd0 = 1;
          e_err = 1; e_rdata = '0;
        end else m_wait++;
`else
        m_wait++;
`endif
      end
      e_done0 = nd0; e_done1 = nd1;
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn) begin
      chk("psel",    PSELx,   m_busy);
      chk("penable", PENABLE, m_busy && m_age == 2);
      chk("paddr",   PADDR,   m_addr);
      chk("pwdata",  PWDATA,  m_wdata);
      chk("pwrite",  PWRITE,  m_write);
      chk("done0",   DONE0,   e_done0);
      chk("done1",   DONE1,   e_done1);
      chk("rdata",   RDATA,   e_rdata);
      chk("err",     ERR,     e_err);
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  int seq[8];
  int nd, c0, c1, gap, n;
  bit seen, prev;

  initial begin
    PRESETn = 0; REQ0 = 0; REQ1 = 0; WRITE0 = 0; WRITE1 = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    PREADY = 0; PRDATA = '0; PSLVERR = 0;
    repeat (3) step();
    chk("rst_psel", PSELx, 0);
    chk("rst_done", {DONE1, DONE0}, 0);
    chk("rst_rdata", RDATA, 0);
    PRESETn = 1;
    step();

    // 1: single write from requester 0, zero wait states
    REQ0 = 1; ADDR0 = 32'h04; WDATA0 = 32'hA5; WRITE0 = 1; PREADY = 1;
    step();
    chk("t1_c1_psel", PSELx, 1); chk("t1_c1_pen", PENABLE, 0); chk("t1_c1_addr", PADDR, 32'h04);
    step();
    chk("t1_c2_pen", PENABLE, 1); chk("t1_c2_wdata", PWDATA, 32'hA5);
    step();
    chk("t1_c3_done0", DONE0, 1); chk("t1_c3_err", ERR, 0); chk("t1_c3_psel", PSELx, 0);
    REQ0 = 0;
    step();
    chk("t1_done_pulse", DONE0, 0);

    // 2: read from requester 1 with four wait states
    REQ1 = 1; ADDR1 = 32'h08; WRITE1 = 0; PREADY = 0; PRDATA = 32'h3C;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_addr_stable", PADDR, 32'h08);
      chk("t2_in_access", {PSELx, PENABLE}, 2'b11);
      if (i == 4) PREADY = 1;
      step();
    end
    chk("t2_done1", DONE1, 1); chk("t2_done0", DONE0, 0); chk("t2_rdata", RDATA, 32'h3C);
    REQ1 = 0;
    step();

    // 3: both requesting continuously, four transfers each
    REQ0 = 1; REQ1 = 1; ADDR0 = 32'h100; ADDR1 = 32'h200; WRITE0 = 1; WRITE1 = 1;
    WDATA0 = 32'h11; WDATA1 = 32'h22; PREADY = 1;
    nd = 0; c0 = 0; c1 = 0; gap = 0; seen = 0; prev = 0;
    for (int cyc = 0; cyc < 80 && nd < 8; cyc++) begin
      step();
      if (!PSELx) gap++;
      else begin
        if (!prev && seen) chk("t3_gap", gap, 1);
        seen = 1; gap = 0;
      end
      prev = PSELx;
      if (DONE0 && nd < 8) begin seq[nd] = 0; nd++; c0++; if (c0 == 4) REQ0 = 0; end
      if (DONE1 && nd < 8) begin seq[nd] = 1; nd++; c1++; if (c1 == 4) REQ1 = 0; end
    end
    REQ0 = 0; REQ1 = 0;
    chk("t3_count", nd, 8);
    for (int i = 0; i < 8; i++) chk("t3_order", seq[i], i % 2);
    step();

    // 4: read ending in slave error
    REQ0 = 1; ADDR0 = 32'h0C; WRITE0 = 0; PSLVERR = 1; PRDATA = 32'h55; PREADY = 1;
    repeat (3) step();
    chk("t4_done0", DONE0, 1); chk("t4_done1", DONE1, 0); chk("t4_err", ERR, 1); chk("t4_rdata", RDATA, 32'h55);
    REQ0 = 0; PSLVERR = 0;
    step();
    step();
    chk("t4_err_held", ERR, 1);

    // 5: reset during ACCESS, then requester 1 alone
    REQ0 = 1; ADDR0 = 32'h40; WRITE0 = 1; PREADY = 0;
    step(); step();
    chk("t5_in_access", PENABLE, 1);
    #2 PRESETn = 0;
    #1;
    chk("t5_rst_psel", PSELx, 0); chk("t5_rst_pen", PENABLE, 0); chk("t5_rst_done", {DONE1, DONE0}, 0);
    REQ0 = 0;
    step(); step();
    PRESETn = 1; REQ1 = 1; ADDR1 = 32'h10; WRITE1 = 0; PRDATA = 32'h77; PREADY = 1;
    step();
    chk("t5_grant1", PADDR, 32'h10); chk("t5_psel", PSELx, 1);
    step();
    chk("t5_no_done0", DONE0, 0);
    step();
    chk("t5_done1", DONE1, 1); chk("t5_done0", DONE0, 0); chk("t5_rdata", RDATA, 32'h77);
    REQ1 = 0;
    step();

`ifdef APB_I2C_SEQ_ARB_TIMEOUT_EN
    // 6: slave never ready
    REQ1 = 1; ADDR1 = 32'h20; WRITE1 = 0; PREADY = 0; PRDATA = 32'hFF;
    step();
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (DONE1) break;
      if (PENABLE) n++;
    end
    chk("t6_done1", DONE1, 1); chk("t6_access_cycles", n, 16);
    chk("t6_err", ERR, 1); chk("t6_rdata", RDATA, 0);
    REQ1 = 0;
    step();
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1);
  end

endmodule

// File: doc/apb_i2c_seq_arb.md
Name: apb_i2c_seq_arb

Overview:
- Two-requester APB master front-end that shares one APB slave port (the i2c controller) between two on-chip requesters.
- Arbitrates round-robin and sequences each request as a compliant APB SETUP/ACCESS transfer.
- Holds the transfer until PREADY, then returns PRDATA/PSLVERR to the granted requester with a one-cycle done pulse.
- Sits between the requesters and the i2c PCLK-domain APB inputs.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 256, max ACCESS cycles waiting for PREADY (used only when the optional feature is enabled)

Ports:
PCLK  in  1  APB clock; sole clock
PRESETn  in  1  asynchronous active-low reset
REQ0 / REQ1  in  1  request from requester 0 / 1; held until its DONE
ADDR0 / ADDR1  in  ADDR_W  request address
WDATA0 / WDATA1  in  DATA_W  write data
WRITE0 / WRITE1  in  1  1=write, 0=read
DONE0 / DONE1  out  1  one-cycle completion pulse to requester 0 / 1
RDATA  out  DATA_W  read data; valid while DONEx=1
ERR  out  1  PSLVERR (or timeout) of completed transfer; valid while DONEx=1
PADDR  out  ADDR_W  APB address to slave
PWDATA  out  DATA_W  APB write data
PWRITE  out  1  APB direction
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Clock and reset: one clock PCLK; reset PRESETn is asynchronous, active-low.
- Reset values (all outputs registered):
  - PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - DONE0=DONE1=0, RDATA=0, ERR=0.
  - State=IDLE; last_grant=1, so requester 0 wins the first tie.
- State IDLE:
  - Eligible requests are REQx AND NOT DONEx; a request whose DONE is high this cycle is masked.
  - If any request is eligible, pick the winner:
    - Only one requester → that one.
    - Both → the one not equal to last_grant.
  - On the winner: latch ADDR/WDATA/WRITE into PADDR/PWDATA/PWRITE, set PSELx=1, update last_grant, go to SETUP.
- State SETUP (one cycle): PENABLE←1, go to ACCESS.
- State ACCESS (PSELx=1, PENABLE=1):
  - PREADY=0: stay; PADDR/PWDATA/PWRITE held stable.
  - PREADY=1: PSELx←0, PENABLE←0; pulse DONE[grant]=1 for one cycle; RDATA←PRDATA if read else 0; ERR←PSLVERR; go to IDLE.
- Latency: REQ sampled high at edge k → SETUP visible after k, ACCESS after k+1, DONE earliest after k+2 (PREADY=1 on first ACCESS cycle). Minimum 3 cycles per transfer.
- Back-to-back: a pending other requester is granted in the IDLE cycle coincident with DONE. Idle gap between consecutive PSELx periods is exactly 1 cycle.
- Requester rules:
  - Drop REQ in the DONE cycle or later; a REQ still high after DONE's cycle is a new request.
  - Command inputs are sampled only at grant; later changes have no effect on the current transfer.
- Simultaneous events:
  - Both requesting continuously → strict alternation 0,1,0,1.
  - A REQ deasserted during SETUP/ACCESS does not abort the transfer; DONE still pulses.
- Reset mid-operation: PSELx/PENABLE drop asynchronously, no DONE is issued, arbiter returns to IDLE with last_grant=1.
- RDATA/ERR are held after DONE until the next completion.

Optional Feature:
- Macro: APB_I2C_SEQ_ARB_TIMEOUT_EN.
- Defined:
  - Counter (clog2(TIMEOUT) bits) clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - On the count reaching TIMEOUT-1 with PREADY still 0: end the transfer as on PREADY, but with ERR=1 and RDATA=0.
- Undefined: no counter; ACCESS waits indefinitely for PREADY. The TIMEOUT parameter is ignored.

Decomposition:
- Package apb_i2c_seq_pkg:
  - State enum {IDLE, SETUP, ACCESS}.
  - Default ADDR_W/DATA_W constants.
  - Requester-index type (1 bit).
- Sub-module apb_rr_pick2: combinational 2-way round-robin picker (req[1:0], last_grant → valid, grant). Instantiated once.

Test Plan:
- Only REQ0, write ADDR0=0x04, WDATA0=0xA5, PREADY=1 → PSELx 1 at cycle 1, PENABLE 1 at cycle 2, DONE0 pulse at cycle 3, ERR=0, PADDR=0x04, PWDATA=0xA5 throughout.
- REQ1 read ADDR1=0x08, PREADY low for 4 ACCESS cycles, PRDATA=0x3C → PADDR stable 0x08 for 5 ACCESS cycles, DONE1 with RDATA=0x3C.
- REQ0 and REQ1 both high from reset, held for 4 transfers each → grant order 0,1,0,1,…; 1-cycle PSELx gap between transfers.
- Read with PSLVERR=1 at PREADY → DONE with ERR=1 to the correct requester; the other DONE stays 0.
- PRESETn asserted during ACCESS → PSELx/PENABLE 0 immediately, no DONE; after release REQ1 alone is granted normally.
- With APB_I2C_SEQ_ARB_TIMEOUT_EN and TIMEOUT=16, PREADY tied 0 → DONE after 16 ACCESS cycles with ERR=1, RDATA=0.
